// File: rtl/dsp_pkg.sv
// Shared DSP slice definitions: latency bound, result record layout and a
// constant-friendly ceiling-log2 helper.
package dsp_pkg;

    localparam int LAT_MAX = 8;
    localparam int P_W     = 48;

    typedef struct packed {
        logic           carry;
        logic [P_W-1:0] p;
    } dsp_res_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_result_collector_if.sv
// Operand-issue and result-delivery signals of the DSP result collector.
interface dsp_result_collector_if #(parameter int W = 48);

    logic         in_valid;
    logic         in_ready;
    logic         issue;
    logic [W-1:0] dsp_p;
    logic         dsp_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_carry;

    modport master (
        output in_valid, dsp_p, dsp_carry, out_ready,
        input  in_ready, issue, out_valid, out_data, out_carry
    );

    modport slave (
        input  in_valid, dsp_p, dsp_carry, out_ready,
        output in_ready, issue, out_valid, out_data, out_carry
    );

endinterface

// File: rtl/dsp_res_fifo.sv
// First-word fall-through result FIFO with synchronous flush; the head reads
// as zero while empty so stale array contents never reach the consumer.
module dsp_res_fifo
    import dsp_pkg::*;
#(
    parameter  int DW    = 49,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          push_s;
    logic          pop_s;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign push_s = push & ~full & ~flush;
    assign pop_s  = pop & ~empty & ~flush;
    assign head   = empty ? '0 : mem_q[rd_q];
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Data array needs no reset; only pointer/count state is architectural.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_q] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_s) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_s) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dsp_res_fifo_chk.sv
// Checker for the result FIFO: a capture must never find the FIFO full.
module dsp_res_fifo_chk (
    input logic CLK,
    input logic rst_n,
    input logic flush,
    input logic push,
    input logic full
);

    // Credit gating guarantees room for every in-flight result.
    a_no_push_full: assert property (@(posedge CLK) disable iff (!rst_n)
        !(push && full && !flush));

endmodule

// File: rtl/dsp_result_collector.sv
// Tracks operand sets through the DSP slice latency, captures P/CARRYOUT when
// they emerge and buffers them; issue is credit-gated so nothing is dropped.
module dsp_result_collector
    import dsp_pkg::*;
#(
    parameter  int W     = 48,
    parameter  int LAT   = 2,
    parameter  int DEPTH = 4,
    localparam int CW    = clog2(DEPTH) + 1,
    localparam int IW    = clog2(LAT_MAX + 1)
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   flush,
    dsp_result_collector_if.slave  bus,
    output logic [IW-1:0]          inflight,
    output logic [CW-1:0]          count,
    output logic [15:0]            res_cnt
);

    logic          issue_s;
    logic          cap_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic          in_ready_s;
    logic [5:0]    credit_s;
    logic [W:0]    head_s;
    logic [CW-1:0] count_s;
    logic [IW-1:0] inflight_q;
    logic [IW-1:0] inflight_d;
    logic [15:0]   res_cnt_q;

    // Credit uses registered state only, so out_ready never reaches in_ready.
    always_comb begin
        credit_s = 6'(count_s) + 6'(inflight_q);
        if (flush) begin
            in_ready_s = 1'b0;
        end else if (credit_s < 6'(DEPTH)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign issue_s       = bus.in_valid & in_ready_s;
    assign pop_s         = ~empty_s & bus.out_ready;
    assign bus.in_ready  = in_ready_s;
    assign bus.issue     = issue_s;
    assign bus.out_valid = ~empty_s;
    assign bus.out_data  = head_s[W-1:0];
    assign bus.out_carry = head_s[W];
    assign inflight      = inflight_q;
    assign count         = count_s;
    assign res_cnt       = res_cnt_q;

    if (LAT == 0) begin : g_nolat
        assign cap_s      = issue_s;
        assign inflight_d = '0;
    end else begin : g_lat
        logic [LAT-1:0] tag_q;
        logic [LAT-1:0] tag_d;

        always_comb begin
            tag_d    = tag_q << 32'd1;
            tag_d[0] = issue_s;
        end

        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                tag_q <= '0;
            end else if (flush) begin
                tag_q <= '0;
            end else begin
                tag_q <= tag_d;
            end
        end

        assign cap_s = tag_q[LAT-1];

        always_comb begin
            inflight_d = inflight_q + {{(IW-1){1'b0}}, issue_s}
                                    - {{(IW-1){1'b0}}, cap_s};
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            res_cnt_q  <= 16'h0000;
        end else if (flush) begin
            inflight_q <= '0;
            res_cnt_q  <= 16'h0000;
        end else begin
            inflight_q <= inflight_d;
            res_cnt_q  <= pop_s ? res_cnt_q + 16'h0001 : res_cnt_q;
        end
    end

    dsp_res_fifo #(.DW(W + 1), .DEPTH(DEPTH)) u_fifo (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (cap_s),
        .push_data ({bus.dsp_carry, bus.dsp_p}),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    dsp_res_fifo_chk u_chk (
        .CLK   (CLK),
        .rst_n (rst_n),
        .flush (flush),
        .push  (cap_s),
        .full  (full_s)
    );

endmodule

// File: tb/tb_dsp_result_collector.sv
// Directed bench: LAT=2 cycle table, LAT=0 streaming and LAT=3 async reset.
module tb_dsp_result_collector;
    import dsp_pkg::*;

    typedef struct {
        logic     fl;
        logic     iv;
        logic     ordy;
        dsp_res_t op;
        logic     ir;
        logic     ov;
        dsp_res_t hd;
        int       cnt;
        int       inf;
        int       res;
    } vec_t;

    localparam int       NV   = 31;
    localparam dsp_res_t JUNK = 49'h1_DEAD_0000_0000;
    localparam dsp_res_t Z    = 49'h0_0000_0000_0000;
    localparam dsp_res_t OA   = 49'h0_0000_0000_1234;
    localparam dsp_res_t B1   = 49'h1_0000_0000_00B1;
    localparam dsp_res_t B2   = 49'h0_0000_0000_00B2;
    localparam dsp_res_t B3   = 49'h1_0000_0000_00B3;
    localparam dsp_res_t B4   = 49'h0_0000_0000_00B4;
    localparam dsp_res_t B5   = 49'h1_0000_0000_00B5;
    localparam dsp_res_t C1   = 49'h0_AAAA_0000_00C1;
    localparam dsp_res_t C2   = 49'h1_AAAA_0000_00C2;
    localparam dsp_res_t C3   = 49'h0_AAAA_0000_00C3;
    localparam dsp_res_t D1   = 49'h1_5555_0000_00D1;
    localparam dsp_res_t D2   = 49'h1_5555_0000_00D2;
    localparam dsp_res_t D3   = 49'h1_5555_0000_00D3;
    localparam dsp_res_t E0   = 49'h0_7777_0000_00E0;
    localparam dsp_res_t E1   = 49'h1_FFFF_FFFF_FFFF;

    logic CLK = 1'b0;
    logic rst_n;
    logic rst3_n;
    logic flush0, flush2, flush3;
    dsp_res_t op0, op2, op3;
    dsp_res_t s2 [2];
    dsp_res_t s3 [3];
    logic [3:0]  inf0, inf2, inf3;
    logic [2:0]  cnt0, cnt2, cnt3;
    logic [15:0] res0, res2, res3;
    int checks = 0;
    int errors = 0;
    vec_t tbl [NV];

    always #5 CLK = ~CLK;

    dsp_result_collector_if #(.W(48)) bus0 ();
    dsp_result_collector_if #(.W(48)) bus2 ();
    dsp_result_collector_if #(.W(48)) bus3 ();

    dsp_result_collector #(.W(48), .LAT(0), .DEPTH(4)) dut0 (
        .CLK(CLK), .rst_n(rst_n), .flush(flush0), .bus(bus0),
        .inflight(inf0), .count(cnt0), .res_cnt(res0));
    dsp_result_collector #(.W(48), .LAT(2), .DEPTH(4)) dut2 (
        .CLK(CLK), .rst_n(rst_n), .flush(flush2), .bus(bus2),
        .inflight(inf2), .count(cnt2), .res_cnt(res2));
    dsp_result_collector #(.W(48), .LAT(3), .DEPTH(4)) dut3 (
        .CLK(CLK), .rst_n(rst3_n), .flush(flush3), .bus(bus3),
        .inflight(inf3), .count(cnt3), .res_cnt(res3));

    // Slice models: the operand issued at edge E appears on P after LAT edges.
    always @(posedge CLK) begin
        s2[0] <= bus2.issue ? op2 : JUNK;
        s2[1] <= s2[0];
        s3[0] <= bus3.issue ? op3 : JUNK;
        s3[1] <= s3[0];
        s3[2] <= s3[1];
    end

    assign bus0.dsp_p     = op0.p;
    assign bus0.dsp_carry = op0.carry;
    assign bus2.dsp_p     = s2[1].p;
    assign bus2.dsp_carry = s2[1].carry;
    assign bus3.dsp_p     = s3[2].p;
    assign bus3.dsp_carry = s3[2].carry;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input int i, input logic fl, input logic iv, input logic ordy,
                       input dsp_res_t op, input logic ir, input logic ov,
                       input dsp_res_t hd, input int cnt, input int inf, input int res);
        tbl[i] = '{fl, iv, ordy, op, ir, ov, hd, cnt, inf, res};
    endtask

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0;
        flush0 = 1'b0; flush2 = 1'b0; flush3 = 1'b0;
        op0 = JUNK; op2 = JUNK; op3 = JUNK;
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
        bus3.in_valid = 1'b0; bus3.out_ready = 1'b0;

        //   i  fl    iv    or    op    ir    ov    head cnt inf res
        put( 0, 1'b0, 1'b1, 1'b1, OA,   1'b1, 1'b0, Z,   0, 0, 0);
        put( 1, 1'b0, 1'b0, 1'b1, JUNK, 1'b1, 1'b0, Z,   0, 1, 0);
        put( 2, 1'b0, 1'b0, 1'b1, JUNK, 1'b1, 1'b0, Z,   0, 1, 0);
        put( 3, 1'b0, 1'b0, 1'b1, JUNK, 1'b1, 1'b1, OA,  1, 0, 0);
        put( 4, 1'b0, 1'b0, 1'b0, JUNK, 1'b1, 1'b0, Z,   0, 0, 1);
        put( 5, 1'b0, 1'b1, 1'b0, B1,   1'b1, 1'b0, Z,   0, 0, 1);
        put( 6, 1'b0, 1'b1, 1'b0, B2,   1'b1, 1'b0, Z,   0, 1, 1);
        put( 7, 1'b0, 1'b1, 1'b0, B3,   1'b1, 1'b0, Z,   0, 2, 1);
        put( 8, 1'b0, 1'b1, 1'b0, B4,   1'b1, 1'b1, B1,  1, 2, 1);
        put( 9, 1'b0, 1'b1, 1'b0, B5,   1'b0, 1'b1, B1,  2, 2, 1);
        put(10, 1'b0, 1'b1, 1'b0, B5,   1'b0, 1'b1, B1,  3, 1, 1);
        put(11, 1'b0, 1'b1, 1'b0, B5,   1'b0, 1'b1, B1,  4, 0, 1);
        put(12, 1'b0, 1'b1, 1'b1, B5,   1'b0, 1'b1, B1,  4, 0, 1);
        put(13, 1'b0, 1'b0, 1'b1, JUNK, 1'b1, 1'b1, B2,  3, 0, 2);
        put(14, 1'b0, 1'b0, 1'b1, JUNK, 1'b1, 1'b1, B3,  2, 0, 3);
        put(15, 1'b0, 1'b0, 1'b1, JUNK, 1'b1, 1'b1, B4,  1, 0, 4);
        put(16, 1'b0, 1'b1, 1'b0, C1,   1'b1, 1'b0, Z,   0, 0, 5);
        put(17, 1'b0, 1'b1, 1'b0, C2,   1'b1, 1'b0, Z,   0, 1, 5);
        put(18, 1'b0, 1'b1, 1'b0, C3,   1'b1, 1'b0, Z,   0, 2, 5);
        put(19, 1'b0, 1'b0, 1'b0, JUNK, 1'b1, 1'b1, C1,  1, 2, 5);
        put(20, 1'b0, 1'b0, 1'b1, JUNK, 1'b1, 1'b1, C1,  2, 1, 5);
        put(21, 1'b0, 1'b1, 1'b0, D1,   1'b1, 1'b1, C2,  2, 0, 6);
        put(22, 1'b0, 1'b1, 1'b0, D2,   1'b1, 1'b1, C2,  2, 1, 6);
        put(23, 1'b1, 1'b1, 1'b1, D3,   1'b0, 1'b1, C2,  2, 2, 6);
        put(24, 1'b0, 1'b0, 1'b0, JUNK, 1'b1, 1'b0, Z,   0, 0, 0);
        put(25, 1'b1, 1'b1, 1'b1, E0,   1'b0, 1'b0, Z,   0, 0, 0);
        put(26, 1'b0, 1'b1, 1'b1, E1,   1'b1, 1'b0, Z,   0, 0, 0);
        put(27, 1'b0, 1'b0, 1'b1, JUNK, 1'b1, 1'b0, Z,   0, 1, 0);
        put(28, 1'b0, 1'b0, 1'b1, JUNK, 1'b1, 1'b0, Z,   0, 1, 0);
        put(29, 1'b0, 1'b0, 1'b1, JUNK, 1'b1, 1'b1, E1,  1, 0, 0);
        put(30, 1'b0, 1'b0, 1'b0, JUNK, 1'b1, 1'b0, Z,   0, 0, 1);

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("reset in_ready", 64'(bus2.in_ready), 64'd1);
        chk("reset out_valid", 64'(bus2.out_valid), 64'd0);
        chk("reset head", 64'({bus2.out_carry, bus2.out_data}), 64'd0);
        chk("reset count", 64'(cnt2), 64'd0);
        chk("reset inflight", 64'(inf2), 64'd0);
        chk("reset res_cnt", 64'(res2), 64'd0);
        rst_n = 1'b1; rst3_n = 1'b1;

        // LAT=2 cycle table
        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            flush2 = tbl[i].fl;
            bus2.in_valid = tbl[i].iv;
            bus2.out_ready = tbl[i].ordy;
            op2 = tbl[i].op;
            #1;
            chk($sformatf("r%0d in_ready", i), 64'(bus2.in_ready), 64'(tbl[i].ir));
            chk($sformatf("r%0d issue", i), 64'(bus2.issue), 64'(tbl[i].ir & tbl[i].iv));
            chk($sformatf("r%0d out_valid", i), 64'(bus2.out_valid), 64'(tbl[i].ov));
            chk($sformatf("r%0d head", i), 64'({bus2.out_carry, bus2.out_data}), 64'(tbl[i].hd));
            chk($sformatf("r%0d count", i), 64'(cnt2), 64'(tbl[i].cnt));
            chk($sformatf("r%0d inflight", i), 64'(inf2), 64'(tbl[i].inf));
            chk($sformatf("r%0d res_cnt", i), 64'(res2), 64'(tbl[i].res));
        end
        flush2 = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;

        // LAT=0: capture in the issue cycle, one result per clock
        for (int k = 0; k < 8; k++) begin
            dsp_res_t fk;
            dsp_res_t fp;
            fk = dsp_res_t'(49'h1_F000_0000_0000 + 49'(k));
            fp = dsp_res_t'(49'h1_F000_0000_0000 + 49'(k - 1));
            @(negedge CLK);
            bus0.in_valid = (k < 6);
            bus0.out_ready = 1'b1;
            op0 = fk;
            #1;
            chk($sformatf("lat0 k%0d in_ready", k), 64'(bus0.in_ready), 64'd1);
            chk($sformatf("lat0 k%0d inflight", k), 64'(inf0), 64'd0);
            chk($sformatf("lat0 k%0d count", k), 64'(cnt0), (k == 0 || k == 7) ? 64'd0 : 64'd1);
            chk($sformatf("lat0 k%0d out_valid", k), 64'(bus0.out_valid), (k == 0 || k == 7) ? 64'd0 : 64'd1);
            chk($sformatf("lat0 k%0d head", k), 64'({bus0.out_carry, bus0.out_data}),
                (k == 0 || k == 7) ? 64'd0 : 64'(fp));
            chk($sformatf("lat0 k%0d res_cnt", k), 64'(res0), (k == 0) ? 64'd0 : 64'(k - 1));
        end
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;

        // LAT=3: asynchronous reset with results in flight and buffered
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            bus3.in_valid = (k < 3);
            bus3.out_ready = 1'b0;
            op3 = dsp_res_t'(49'h1_0303_0000_0000 + 49'(k));
        end
        #1;
        chk("lat3 pre inflight", 64'(inf3), 64'd2);
        chk("lat3 pre count", 64'(cnt3), 64'd1);
        chk("lat3 pre head", 64'({bus3.out_carry, bus3.out_data}), 64'h1_0303_0000_0000);
        #2;
        rst3_n = 1'b0;
        #1;
        chk("lat3 rst out_valid", 64'(bus3.out_valid), 64'd0);
        chk("lat3 rst head", 64'({bus3.out_carry, bus3.out_data}), 64'd0);
        chk("lat3 rst inflight", 64'(inf3), 64'd0);
        chk("lat3 rst count", 64'(cnt3), 64'd0);
        chk("lat3 rst res_cnt", 64'(res3), 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        rst3_n = 1'b1;
        bus3.in_valid = 1'b0;
        bus3.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("lat3 post k%0d in_ready", k), 64'(bus3.in_ready), 64'd1);
            chk($sformatf("lat3 post k%0d out_valid", k), 64'(bus3.out_valid), 64'd0);
            chk($sformatf("lat3 post k%0d inflight", k), 64'(inf3), 64'd0);
            @(negedge CLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
